// File: rtl/sync_tx_pkg.sv
// Shared types and constants for the sync_serial_tx frame transmitter.
// Optional feature macro: SYNC_SERIAL_TX_PARITY_EN (adds the PAR state).
package sync_tx_pkg;

    // Header driven ahead of every payload, MSB first.
    localparam logic [3:0]  SYNC_PATTERN = 4'b1101;
    localparam int unsigned SYNC_LEN     = 4;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StSync = 3'd1,
        StData = 3'd2,
`ifdef SYNC_SERIAL_TX_PARITY_EN
        StPar  = 3'd3,
`endif
        StGap  = 3'd4
    } tx_state_t;

    // Largest of three lengths, used to size the bit-position counter.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_tx_counter.sv
// Loadable down-counter tracking the bit position inside the current frame state.
// last_o flags the final cycle of a state (count == 1).
module sync_tx_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_next_o,
    output logic             last_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins over decrement; never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_next_o = cnt_d;
    assign last_o       = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/sync_serial_tx.sv
// Serial frame transmitter: 1101 header, MSB-first payload, optional even parity,
// then GAP_LEN idle zeros. One bit per clock on a registered output.
// Optional feature macro: SYNC_SERIAL_TX_PARITY_EN (parity bit after the data).
module sync_serial_tx
    import sync_tx_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned GAP_LEN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              o,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned MaxLen = max3(DATA_W, GAP_LEN, SYNC_LEN);
    localparam int unsigned CntW   = $clog2(MaxLen) + 1;

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              o_q, o_d;

    logic              cnt_load;
    logic [CntW-1:0]   cnt_load_val;
    logic              cnt_dec;
    logic [CntW-1:0]   cnt_next;
    logic              cnt_last;
    logic              sync_bit;

`ifdef SYNC_SERIAL_TX_PARITY_EN
    logic              par_q, par_d;
`endif

    sync_tx_counter #(
        .WIDTH (CntW)
    ) u_counter (
        .clk          (clk),
        .rst          (rst),
        .load_i       (cnt_load),
        .load_val_i   (cnt_load_val),
        .dec_i        (cnt_dec),
        .count_next_o (cnt_next),
        .last_o       (cnt_last)
    );

    // Next-state logic: each state entry reloads the counter with its length.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
`ifdef SYNC_SERIAL_TX_PARITY_EN
        par_d        = par_q;
`endif
        unique case (state_q)
            StIdle: begin
                // tx_ready is high only here, so the handshake is just tx_valid.
                if (tx_valid) begin
                    state_d      = StSync;
                    shift_d      = tx_data;
                    cnt_load     = 1'b1;
                    cnt_load_val = CntW'(SYNC_LEN);
`ifdef SYNC_SERIAL_TX_PARITY_EN
                    par_d        = ^tx_data;
`endif
                end
            end
            StSync: begin
                if (cnt_last) begin
                    state_d      = StData;
                    cnt_load     = 1'b1;
                    cnt_load_val = CntW'(DATA_W);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StData: begin
                // The bit on the line now is shift_q MSB; expose the next one.
                shift_d = shift_q << 1;
                if (cnt_last) begin
`ifdef SYNC_SERIAL_TX_PARITY_EN
                    state_d      = StPar;
                    cnt_load     = 1'b1;
                    cnt_load_val = CntW'(1);
`else
                    state_d      = StGap;
                    cnt_load     = 1'b1;
                    cnt_load_val = CntW'(GAP_LEN);
`endif
                end else begin
                    cnt_dec = 1'b1;
                end
            end
`ifdef SYNC_SERIAL_TX_PARITY_EN
            StPar: begin
                if (cnt_last) begin
                    state_d      = StGap;
                    cnt_load     = 1'b1;
                    cnt_load_val = CntW'(GAP_LEN);
                end else begin
                    cnt_dec = 1'b1;
                end
            end
`endif
            StGap: begin
                if (cnt_last) begin
                    state_d      = StIdle;
                    cnt_load     = 1'b1;
                    cnt_load_val = '0;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d      = StIdle;
                cnt_load     = 1'b1;
                cnt_load_val = '0;
            end
        endcase
    end

    // Header bit selected by the counter value the next cycle will hold (4..1).
    always_comb begin
        sync_bit = 1'b0;
        for (int i = 0; i < int'(SYNC_LEN); i++) begin
            if (cnt_next == CntW'(i + 1)) begin
                sync_bit = SYNC_PATTERN[i];
            end
        end
    end

    // Output bit is computed from the next state so o lines up with state_q.
    always_comb begin
        o_d = 1'b0;
        case (state_d)
            StSync:  o_d = sync_bit;
            StData:  o_d = shift_d[DATA_W-1];
`ifdef SYNC_SERIAL_TX_PARITY_EN
            StPar:   o_d = par_q;
`endif
            default: o_d = 1'b0;
        endcase
    end

    // State, shift register and line register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            shift_q <= '0;
            o_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            o_q     <= o_d;
        end
    end

`ifdef SYNC_SERIAL_TX_PARITY_EN
    // Parity of the latched word, captured at the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign frame_done = (state_q == StPar) && cnt_last;
`else
    assign frame_done = (state_q == StData) && cnt_last;
`endif

    assign o        = o_q;
    assign tx_ready = (state_q == StIdle);
    assign busy     = ~tx_ready;

endmodule

// File: tb/tb_sync_serial_tx.sv
// Self-checking bench for sync_serial_tx: vector table, hand sequences, random frames
// against a frame-level model, and a loopback into a '1101' Mealy detector.
module tb_sync_serial_tx;

    localparam int DW  = 8;
    localparam int GL  = 1;
    localparam int LDW = 4;
    localparam int LGL = 2;
`ifdef SYNC_SERIAL_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int PERIOD  = 5 + DW + P + GL;
    localparam int LPERIOD = 5 + LDW + P + LGL;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready, o, busy, frame_done;

    logic [LDW-1:0] lb_data;
    logic           lb_valid;
    logic           lb_ready, lb_o, lb_busy, lb_fd;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    sync_serial_tx #(
        .DATA_W  (DW),
        .GAP_LEN (GL)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .o          (o),
        .busy       (busy),
        .frame_done (frame_done)
    );

    sync_serial_tx #(
        .DATA_W  (LDW),
        .GAP_LEN (LGL)
    ) u_dut_lb (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (lb_data),
        .tx_valid   (lb_valid),
        .tx_ready   (lb_ready),
        .o          (lb_o),
        .busy       (lb_busy),
        .frame_done (lb_fd)
    );

    // Behavioural Mealy '1101' detector on the loopback line (overlapping).
    logic [2:0] det_hist;
    logic       det_pulse;
    always @(posedge clk) begin
        if (rst) det_hist <= 3'b000;
        else     det_hist <= {det_hist[1:0], lb_o};
    end
    assign det_pulse = ({det_hist, lb_o} == 4'b1101);

    typedef struct {
        logic [7:0] data;
        int         ones;  // 1s on the line for header+data
        int         par;   // even-parity bit of data
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        tx_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            step();
            chk("idle", 32'({tx_ready, busy, o, frame_done}), 32'(4'b1000));
        end
    endtask

    // Sends one word and checks every cycle of the frame against a model built
    // from the frame format (header, MSB-first data, parity, zero gap).
    task automatic run_frame(input logic [DW-1:0] w, input bit keep, output int ones,
                             output int start);
        bit exp_o[$];
        int fd_cyc;
        fd_cyc = 4 + DW + P;
        exp_o  = {1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = DW - 1; i >= 0; i--) exp_o.push_back(w[i]);
        if (P == 1) exp_o.push_back(($countones(w) % 2) == 1);
        for (int g = 0; g < GL; g++) exp_o.push_back(1'b0);
        tx_data  = w;
        tx_valid = 1'b1;
        step();
        start    = cyc;
        tx_valid = keep;
        ones     = 0;
        for (int c = 1; c < PERIOD; c++) begin
            chk($sformatf("o c%0d", c), 32'(o), 32'(exp_o[c-1]));
            chk($sformatf("frame_done c%0d", c), 32'(frame_done), 32'(c == fd_cyc));
            chk($sformatf("ready/busy c%0d", c), 32'({tx_ready, busy}), 32'(2'b01));
            if (o) ones++;
            tx_data = DW'($urandom);
            step();
        end
        chk("ready back", 32'({tx_ready, busy, o, frame_done}), 32'(4'b1000));
    endtask

    initial begin
        int ones, s0, s1, lb_pulses, lb_fds, lb_bad;
        logic [DW-1:0] w;

        tbl[0] = '{data: 8'hA5, ones: 7,  par: 0};
        tbl[1] = '{data: 8'h07, ones: 6,  par: 1};
        tbl[2] = '{data: 8'hC3, ones: 7,  par: 0};
        tbl[3] = '{data: 8'h01, ones: 4,  par: 1};
        tbl[4] = '{data: 8'h3C, ones: 7,  par: 0};
        tbl[5] = '{data: 8'h80, ones: 4,  par: 1};

        rst      = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        lb_valid = 1'b0;
        lb_data  = '0;

        // Reset state
        step();
        chk("reset 1", 32'({tx_ready, busy, o, frame_done}), 32'(4'b1000));
        step();
        chk("reset 2", 32'({tx_ready, busy, o, frame_done}), 32'(4'b1000));
        rst = 1'b0;
        idle_cycles(5);

        // Table vectors
        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].data, 1'b0, ones, s0);
            chk($sformatf("ones %0h", tbl[i].data), 32'(ones), 32'(tbl[i].ones + P * tbl[i].par));
            idle_cycles(1);
        end

        // Back-to-back with tx_valid held and tx_data scrambled mid-frame
        run_frame(8'hFF, 1'b1, ones, s0);
        chk("b2b ones FF", 32'(ones), 32'(11));
        run_frame(8'h00, 1'b0, ones, s1);
        chk("b2b spacing", 32'(s1 - s0), 32'(PERIOD));
        idle_cycles(2);

        // Reset mid-frame during data bit 3 of C3
        tx_data  = 8'hC3;
        tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (7) step();
        chk("mid data bit", 32'(o), 32'(0));
        chk("mid busy", 32'({tx_ready, busy}), 32'(2'b01));
        rst = 1'b1;
        step();
        chk("abort", 32'({tx_ready, busy, o, frame_done}), 32'(4'b1000));
        rst = 1'b0;
        idle_cycles(3);
        run_frame(8'h3C, 1'b0, ones, s0);
        chk("post-reset ones", 32'(ones), 32'(7));

        // Random frames with random idle gaps and random back-to-back
        for (int r = 0; r < 24; r++) begin
            idle_cycles(int'($urandom_range(0, 3)));
            w = DW'($urandom);
            run_frame(w, bit'($urandom_range(0, 1)), ones, s0);
            chk("rand ones", 32'(ones), 32'(3 + $countones(w) + P * ($countones(w) % 2)));
        end
        idle_cycles(2);

        // Loopback into the Mealy detector: 4'h0 then 4'h2, tx_valid held
        lb_data  = 4'h0;
        lb_valid = 1'b1;
        step();
        lb_pulses = 0;
        lb_fds    = 0;
        lb_bad    = 0;
        for (int k = 1; k <= 2 * LPERIOD + 3; k++) begin
            chk($sformatf("detector k%0d", k), 32'(det_pulse),
                32'((k == 4) || (k == LPERIOD + 4)));
            if (det_pulse) lb_pulses++;
            if (lb_fd) lb_fds++;
            if (lb_busy == lb_ready) lb_bad++;
            if (k == 1) lb_data = 4'h2;
            if (k == LPERIOD + 1) lb_valid = 1'b0;
            step();
        end
        chk("lb pulses", 32'(lb_pulses), 32'(2));
        chk("lb frame_done", 32'(lb_fds), 32'(2));
        chk("lb busy", 32'(lb_bad), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
